// File: rtl/distributor_mc.sv
// rtl/distributor_mc.sv - routes commutator samples to drop, side registers or stream FIFO
module distributor_mc #(
    parameter int DW = 12,
    parameter int AW = 5,
    parameter logic [2**AW-1:0] IGNORE_MASK = 32'h0000_0002,
    parameter logic [2**AW-1:0] SIDE_MASK = 32'h0002_0000,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DW-1:0]     data,
    input  logic              valid,
    input  logic [AW-1:0]     address,
    input  logic              fFull,
    output logic [DW-1:0]     fData,
    output logic [AW-1:0]     fAddr,
    output logic              fWrEn,
    input  logic [AW-1:0]     side_rd_addr,
    output logic [DW-1:0]     side_rd_data,
    output logic              side_upd,
    input  logic              drop_clr,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_HOLD
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] cap_data;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] side_reg [2**AW];
    logic          dispatch;
    logic          is_ignore;
    logic          is_side;
    logic          is_stream;
    logic          do_write;
    logic          do_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (valid) state_nxt = ST_DISPATCH;
            ST_DISPATCH: state_nxt = ST_HOLD;
            ST_HOLD:     if (!valid) state_nxt = ST_IDLE;
            default:     state_nxt = ST_HOLD;
        endcase
    end

    always_comb begin
        dispatch  = (state == ST_DISPATCH);
        is_ignore = IGNORE_MASK[cap_addr];
        is_side   = !is_ignore && SIDE_MASK[cap_addr];
        is_stream = !is_ignore && !is_side;
        do_write  = dispatch && is_stream && !fFull;
        do_drop   = dispatch && is_stream && fFull;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_data <= '0;
            cap_addr <= '0;
            fData    <= '0;
            fAddr    <= '0;
            fWrEn    <= 1'b0;
            side_upd <= 1'b0;
        end else begin
            if (state == ST_IDLE && valid) begin
                cap_data <= data;
                cap_addr <= address;
            end
            if (do_write) begin
                fData <= cap_data;
                fAddr <= cap_addr;
            end
            fWrEn    <= do_write;
            side_upd <= dispatch && is_side;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**AW; i++) begin
                side_reg[i] <= '0;
            end
            side_rd_data <= '0;
        end else begin
            if (dispatch && is_side) begin
                side_reg[cap_addr] <= cap_data;
            end
            side_rd_data <= side_reg[side_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop_clr) begin
            drop_cnt <= '0;
        end else if (do_drop && drop_cnt != {DROP_W{1'b1}}) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

endmodule
